sha256_w_stream_reader: RTL

- Sequential, word-serial SHA-256 message-schedule engine.
- Accepts one 512-bit padded block through a valid/ready handshake and emits the full W schedule, W0..W63, one 32-bit word per accepted output beat.
- Keeps a 16-word sliding window and applies the standard σ0/σ1 recurrence.
- Serves as the iterative counterpart to the pipelined, windowed W-memory stages: it produces the W words that an iterative compression core reads.

---
 rtl/sha256_w_stream_reader_if.sv | 22 ++
 rtl/sha256_w_stream_reader.sv | 90 +++++++++
 2 files changed

// File: rtl/sha256_w_stream_reader_if.sv
// Block-in / word-out handshake bundle for the SHA-256 schedule reader.
// master drives blocks and consumes words; slave is the schedule engine.
interface sha256_w_stream_reader_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;

    modport master (
        output in_valid, block_in, w_ready,
        input  in_ready, w_valid, w_out, w_idx, w_last
    );

    modport slave (
        input  in_valid, block_in, w_ready,
        output in_ready, w_valid, w_out, w_idx, w_last
    );
endinterface

// File: rtl/sha256_w_stream_reader.sv
// Word-serial SHA-256 message schedule: loads one 512-bit block and
// streams W0..W63 over a valid/ready port from a 16-word sliding window.
module sha256_w_stream_reader #(
    parameter int NUM_WORDS = 64
) (
    input  logic CLK,
    input  logic RST,
    sha256_w_stream_reader_if.slave bus,
    output logic busy
);
    localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic        load;
    logic        adv;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(
        input logic [31:0] x,
        input int          n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.w_ready) begin
                    adv = 1'b1;
                    if (t == LAST)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            t     <= '0;
            for (int i = 0; i < 16; i++)
                win[i] <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                t <= '0;
                for (int i = 0; i < 16; i++)
                    win[i] <= bus.block_in[511 - 32*i -: 32];
            end else if (adv) begin
                // window slides one word; the tail takes W[t+16]
                for (int i = 0; i < 15; i++)
                    win[i] <= win[i+1];
                win[15] <= w_new;
                t       <= (t == LAST) ? 6'd0 : t + 6'd1;
            end
        end
    end

    assign busy         = (state == STREAM);
    assign bus.in_ready = (state == IDLE);
    assign bus.w_valid  = busy;
    assign bus.w_out    = busy ? win[0] : 32'd0;
    assign bus.w_idx    = t;
    assign bus.w_last   = busy && (t == LAST);
endmodule
